// File: rtl/fetch_predict_unit.sv
// ---------------------------------------------------------------------------
// fetch_predict_unit
//
// Instruction-fetch stage with an integrated tagged, direct-mapped branch
// target buffer (BTB). Each BTB entry holds a valid bit, a tag, a target
// address and a 2-bit saturating direction counter.
//
// The unit owns the PC register. It drives the instruction-memory address
// and registers an IF/ID bundle (pc, inst, prediction) for decode. Resolved
// branches from the back end train the BTB. Mispredictions and exceptions
// redirect the PC through a single redirect port.
//
// Ports
//   clk             core clock, rising edge
//   rst             asynchronous, active-low reset
//   stall           hazard stall: holds the PC and the IF/ID register
//   redirect_valid  back-end redirect (mispredict/exception)
//   redirect_pc     redirect target
//   upd_valid       resolved-branch training strobe
//   upd_pc          PC of the resolved branch
//   upd_taken       actual branch outcome
//   upd_target      actual branch target
//   imem_addr       instruction-memory address (= current PC)
//   imem_inst       instruction returned combinationally for imem_addr
//   pc              current PC
//   if_valid        IF/ID bundle valid
//   if_pc           registered PC of the bundle
//   if_inst         registered instruction
//   if_pred_taken   prediction used for this bundle
//   if_pred_target  predicted target (0 when not taken)
// ---------------------------------------------------------------------------
module fetch_predict_unit #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [1:0]      CNT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_inst,
  output logic [XLEN-1:0] pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target
);

  localparam int IDXW = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDXW - 2;

  // -------------------------------------------------------------------------
  // BTB storage
  // -------------------------------------------------------------------------
  logic [BTB_DEPTH-1:0] btb_valid;
  logic [1:0]           btb_cnt    [BTB_DEPTH];
  logic [TAGW-1:0]      btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      btb_target [BTB_DEPTH];

  // -------------------------------------------------------------------------
  // Lookup on the current PC (combinational). Bits [1:0] are ignored.
  // -------------------------------------------------------------------------
  logic [IDXW-1:0] lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  assign lk_idx      = pc[IDXW+1:2];
  assign lk_tag      = pc[XLEN-1:IDXW+2];
  assign lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && btb_cnt[lk_idx][1];
  assign pred_target = btb_target[lk_idx];

  assign imem_addr = pc;

  // -------------------------------------------------------------------------
  // Training port decode
  // -------------------------------------------------------------------------
  logic [IDXW-1:0] up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;
  logic            up_alloc;
  logic [1:0]      up_cnt_next;

  assign up_idx   = upd_pc[IDXW+1:2];
  assign up_tag   = upd_pc[XLEN-1:IDXW+2];
  assign up_hit   = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
  assign up_alloc = upd_valid && !up_hit && upd_taken;

  // The low two bits of the update PC never select anything.
  logic unused_upd_lsbs;
  assign unused_upd_lsbs = &{1'b0, upd_pc[1:0]};

  // Saturating counter step for a hit; a taken miss allocates at 2'b10.
  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    up_cnt_next = btb_cnt[up_idx];
    if (!up_hit) begin
      up_cnt_next = 2'b10;
    end else if (upd_taken) begin
      if (btb_cnt[up_idx] != 2'b11) up_cnt_next = btb_cnt[up_idx] + 2'b01;
    end else begin
      if (btb_cnt[up_idx] != 2'b00) up_cnt_next = btb_cnt[up_idx] - 2'b01;
    end
  end

  // -------------------------------------------------------------------------
  // Next-PC selection: redirect > stall > predicted taken > sequential.
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] pc_next;

  always_comb begin
    pc_next = pc + XLEN'(4);
    if (redirect_valid)  pc_next = redirect_pc;
    else if (stall)      pc_next = pc;
    else if (pred_taken) pc_next = pred_target;
  end

  // -------------------------------------------------------------------------
  // PC and IF/ID register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc             <= RESET_PC;
      if_valid       <= 1'b0;
      if_pc          <= '0;
      if_inst        <= '0;
      if_pred_taken  <= 1'b0;
      if_pred_target <= '0;
    end else begin
      pc <= pc_next;
      if (redirect_valid) begin
        // The squashed bundle's other fields are don't-care; leave them.
        if_valid <= 1'b0;
      end else if (!stall) begin
        if_valid       <= 1'b1;
        if_pc          <= pc;
        if_inst        <= imem_inst;
        if_pred_taken  <= pred_taken;
        if_pred_target <= pred_taken ? pred_target : '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // BTB valid bits and counters (reset). Training is independent of stall
  // and redirect; the lookup above always sees the pre-update contents.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) btb_cnt[i] <= CNT_INIT;
    end else if (upd_valid && (up_hit || upd_taken)) begin
      btb_valid[up_idx] <= 1'b1;
      btb_cnt[up_idx]   <= up_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // BTB tag and target arrays.
  // NOTE: these arrays have no reset; an entry is only trusted once its valid
  // bit is set, so leaving them uninitialised keeps them plain RAM.
  // Writes are still gated by rst so training that coincides with reset is
  // dropped.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst && upd_valid && upd_taken) begin
      btb_target[up_idx] <= upd_target;
      if (up_alloc) btb_tag[up_idx] <= up_tag;
    end
  end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_predict_unit
//
// Self-checking bench for fetch_predict_unit. A behavioural model (plain
// arrays and integer arithmetic) tracks the PC, the IF/ID bundle and the
// BTB contents. Directed sequences come first, followed by randomized traffic
// concentrated on a small address pool so that entries hit and alias often.
// ---------------------------------------------------------------------------
module tb_fetch_predict_unit;

  localparam int          XLEN      = 32;
  localparam int          BTB_DEPTH = 16;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          CNT_INIT  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  fetch_predict_unit #(
    .XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH), .RESET_PC(RESET_PC), .CNT_INIT(2'b01)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .pc(pc), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target)
  );

  // Instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A3C_0F13;
  endfunction

  assign imem_inst = inst_of(imem_addr);

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  bit          m_vld [BTB_DEPTH];
  int unsigned m_tag [BTB_DEPTH];
  logic [31:0] m_tgt [BTB_DEPTH];
  int          m_cnt [BTB_DEPTH];
  logic [31:0] m_pc;
  bit          m_ifv;
  logic [31:0] m_if_pc, m_if_inst, m_if_ptgt;
  bit          m_if_pt;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % BTB_DEPTH);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (4 * BTB_DEPTH);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC;
    m_ifv = 0;
    m_if_pc = '0; m_if_inst = '0; m_if_pt = 0; m_if_ptgt = '0;
    for (int i = 0; i < BTB_DEPTH; i++) begin
      m_vld[i] = 0;
      m_cnt[i] = CNT_INIT;
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int  li, ui;
    bit  hit, pt, uhit;
    logic [31:0] ptgt;
    li   = idx_of(m_pc);
    hit  = m_vld[li] && (m_tag[li] == tag_of(m_pc));
    pt   = hit && (m_cnt[li] >= 2);
    ptgt = m_tgt[li];

    if (redirect_valid) begin
      m_ifv = 0;
    end else if (!stall) begin
      m_ifv     = 1;
      m_if_pc   = m_pc;
      m_if_inst = inst_of(m_pc);
      m_if_pt   = pt;
      m_if_ptgt = pt ? ptgt : 32'h0;
    end

    if (redirect_valid) m_pc = redirect_pc;
    else if (stall)     m_pc = m_pc;
    else if (pt)        m_pc = ptgt;
    else                m_pc = m_pc + 32'd4;

    if (upd_valid) begin
      ui   = idx_of(upd_pc);
      uhit = m_vld[ui] && (m_tag[ui] == tag_of(upd_pc));
      if (uhit) begin
        if (upd_taken) begin
          m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
          m_tgt[ui] = upd_target;
        end else begin
          m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_vld[ui] = 1;
        m_tag[ui] = tag_of(upd_pc);
        m_tgt[ui] = upd_target;
        m_cnt[ui] = 2;
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("if_valid", {31'b0, if_valid}, {31'b0, m_ifv});
    if (m_ifv) begin
      check("if_pc", if_pc, m_if_pc);
      check("if_inst", if_inst, m_if_inst);
      check("if_pred_taken", {31'b0, if_pred_taken}, {31'b0, m_if_pt});
      check("if_pred_target", if_pred_target, m_if_ptgt);
    end
  endtask

  // One clock: drive inputs (called at a negedge), step the model, let the
  // DUT take the rising edge, then compare at the following falling edge.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg);
    stall = st; redirect_valid = rv; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redir(input logic [31:0] a);
    cycle(0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic train(input logic [31:0] a, input logic t, input logic [31:0] tg);
    cycle(0, 0, 0, 1, a, t, tg);
  endtask

  function automatic logic [31:0] pool_addr();
    return 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 2) * 64);
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    stall = 0; redirect_valid = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    model_reset();

    // Reset state
    #12;
    check("rst_pc", pc, RESET_PC);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_if_pred_taken", {31'b0, if_pred_taken}, 32'd0);
    check("rst_if_pred_target", if_pred_target, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check_all();

    // Sequential fetch after reset
    idle();
    check("seq_pc1", pc, 32'h4);
    check("seq_if_pc0", if_pc, 32'h0);
    idle();
    check("seq_pc2", pc, 32'h8);
    check("seq_if_pc1", if_pc, 32'h4);
    check("seq_inst1", if_inst, inst_of(32'h4));

    // Allocation on a taken miss, then predicted fetch
    train(32'h10, 1, 32'h40);
    redir(32'h10);
    check("redir_if_valid", {31'b0, if_valid}, 32'd0);
    idle();
    check("alloc_next_pc", pc, 32'h40);
    check("alloc_pred_taken", {31'b0, if_pred_taken}, 32'd1);
    check("alloc_pred_target", if_pred_target, 32'h40);

    // Counter decrement and saturation at zero
    train(32'h10, 0, 0);
    train(32'h10, 0, 0);
    redir(32'h10);
    idle();
    check("nt_next_pc", pc, 32'h14);
    for (int i = 0; i < 3; i++) train(32'h10, 0, 0);
    for (int i = 0; i < 4; i++) train(32'h10, 1, 32'h40);
    redir(32'h10);
    idle();
    check("sat_hi_next_pc", pc, 32'h40);
    train(32'h10, 0, 0);
    train(32'h10, 0, 0);
    redir(32'h10);
    idle();
    check("sat_hi_dec_pc", pc, 32'h14);

    // Aliasing entry: same index, different tag
    train(32'h10, 1, 32'h40);
    redir(32'h50);
    idle();
    check("alias_miss_pc", pc, 32'h54);
    train(32'h50, 1, 32'h80);
    redir(32'h10);
    idle();
    check("replaced_miss_pc", pc, 32'h14);
    redir(32'h50);
    idle();
    check("replaced_hit_pc", pc, 32'h80);

    // Lookup and update to the same index in one cycle
    redir(32'h20);
    train(32'h20, 1, 32'h60);
    check("same_cycle_pc", pc, 32'h24);
    redir(32'h20);
    idle();
    check("same_cycle_later_pc", pc, 32'h60);

    // Redirect wins over stall; then plain stall holds everything
    cycle(1, 1, 32'h100, 0, 0, 0, 0);
    check("stall_redir_pc", pc, 32'h100);
    check("stall_redir_valid", {31'b0, if_valid}, 32'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 0);
      check("stall_hold_pc", pc, 32'h104);
      check("stall_hold_if_pc", if_pc, 32'h100);
    end

    // PC wraps modulo 2^32
    redir(32'hFFFF_FFFC);
    idle();
    check("wrap_pc", pc, 32'h0);

    // Mid-run reset after training
    train(32'h10, 1, 32'h40);
    train(32'h10, 1, 32'h40);
    cycle(0, 0, 0, 1, 32'h30, 1, 32'h90);
    rst = 1'b0;
    #1;
    check("midrst_pc", pc, RESET_PC);
    check("midrst_if_valid", {31'b0, if_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    check_all();
    redir(32'h10);
    idle();
    check("post_rst_no_pred", pc, 32'h14);
    redir(32'h30);
    idle();
    check("post_rst_discard", pc, 32'h34);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic        st, rv, uv, ut;
      logic [31:0] rpc, upc, utg;
      st  = ($urandom % 5) == 0;
      rv  = ($urandom % 7) == 0;
      rpc = pool_addr();
      uv  = ($urandom % 3) == 0;
      upc = (($urandom % 2) == 0) ? m_pc : pool_addr();
      ut  = ($urandom % 3) != 0;
      utg = pool_addr();
      cycle(st, rv, rpc, uv, upc, ut, utg);
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_predict_unit.md
Name: fetch_predict_unit

Overview:
Parametrised instruction-fetch stage with an integrated tagged, direct-mapped branch target buffer. Each BTB entry carries a per-entry 2-bit saturating direction counter. It owns the PC register, drives the instruction-memory address, and presents a registered IF/ID bundle (pc, inst, prediction) to decode. Resolved branches from the back end train the table. Mispredictions and exceptions redirect the PC through a single redirect port.

Parameters:
XLEN, 32, datapath/address width
BTB_DEPTH, 16, BTB entries; power of two, >= 2; IDXW = log2(BTB_DEPTH)
RESET_PC, 32'h0000_0000, PC value after reset
CNT_INIT, 2'b01, counter value loaded at reset (weakly not-taken)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hazard stall; holds PC and IF/ID register
redirect_valid  in  1  back-end redirect (mispredict/exception)
redirect_pc  in  XLEN  redirect target
upd_valid  in  1  resolved-branch training strobe
upd_pc  in  XLEN  PC of the resolved branch
upd_taken  in  1  actual branch outcome
upd_target  in  XLEN  actual branch target
imem_addr  out  XLEN  instruction-memory address (= current PC)
imem_inst  in  32  instruction returned combinationally for imem_addr
pc  out  XLEN  current PC
if_valid  out  1  IF/ID bundle valid
if_pc  out  XLEN  registered PC of the bundle
if_inst  out  32  registered instruction
if_pred_taken  out  1  prediction used for this bundle
if_pred_target  out  XLEN  predicted target (0 when not taken)

Behaviour:
- Reset (rst=0, async): pc=RESET_PC; all BTB valid bits=0; all counters=CNT_INIT; if_valid=0; if_pc, if_inst, if_pred_taken, if_pred_target=0. Tag and target arrays need no reset.
- Indexing: idx = addr[IDXW+1:2]; tag = addr[XLEN-1:IDXW+2]. Bits [1:0] are ignored.
- Lookup is combinational on pc. hit = valid[idx] & (tag[idx]==pc tag). pred_taken = hit & cnt[idx][1]. pred_target = target[idx].
- Next PC priority, applied at each rising edge:
  1. redirect_valid: pc <= redirect_pc.
  2. stall: pc holds.
  3. pred_taken: pc <= pred_target.
  4. Otherwise: pc <= pc+4, wrapping modulo 2^XLEN.
- IF/ID register, same edge, same priority:
  - redirect_valid: if_valid <= 0; other IF/ID fields are don't-care.
  - stall: all IF/ID fields hold.
  - Otherwise: if_valid <= 1; capture pc, imem_inst, pred_taken, and pred_taken ? pred_target : 0.
- Redirect overrides a simultaneous stall.
- First edge after reset loads the bundle for RESET_PC. Fetch-to-IF/ID latency is 1 cycle.
- Training occurs on an upd_valid edge, at idx/tag of upd_pc, and is independent of stall and redirect:
  - Entry hit (valid and tag match):
    - Counter +1 if upd_taken, saturating at 2'b11.
    - Counter -1 if not taken, saturating at 2'b00.
    - If upd_taken, target <= upd_target.
  - Entry miss, upd_taken=1: allocate/replace the entry: valid=1, tag, target=upd_target, counter=2'b10.
  - Entry miss, upd_taken=0: no change.
- Simultaneous lookup and update to the same index: the lookup uses pre-update contents. The write is visible from the next cycle.
- Reset asserted mid-operation: all state returns to reset values immediately. Training in flight is discarded.

Test Plan:
- Release reset, no update/stall -> pc sequence 0x0, 0x4, 0x8. if_valid=0 in the first cycle, then if_pc 0x0, 0x4. Bundle inst equals imem_inst sampled at that pc.
- upd_valid, upd_pc=0x10, upd_taken=1, upd_target=0x40 -> entry 4 allocated with counter 2'b10. Next fetch of 0x10 gives next pc 0x40, if_pred_taken=1, if_pred_target=0x40.
- Two not-taken updates to 0x10 -> counter 2'b01 then 2'b00; fetch 0x10 goes to 0x14. Three further not-taken updates keep it at 2'b00. Four taken updates saturate it at 2'b11.
- With 0x10 trained taken, fetch 0x50 (same idx 4, tag 1) -> no hit, next pc 0x54. A taken update at 0x50 replaces the entry, and 0x10 then misses.
- stall=1 and redirect_valid=1 with redirect_pc=0x100 in the same cycle -> pc=0x100 and if_valid=0 next cycle. Stall alone for 3 cycles -> pc and bundle held unchanged.
- Assert rst mid-run after training -> pc=RESET_PC and if_valid=0 asynchronously. After release, 0x10 no longer predicts taken.
